irq_capture_resolver: RTL
=========================

// Module: irq_capture_resolver
// PURPOSE
//  Parametrised interrupt request/in-service unit for the PIC datapath. Each channel synchronises,
//  captures (edge or level) and masks its request. A fixed-priority resolver raises int_out, and
//  a two-pulse INTA state machine hands one vector to the data-bus block. In-service state is held
//  until an EOI command clears it.
// PARAMETERS
//  NUM_IRQ      8   number of request channels; index 0 = highest priority
//  VEC_W        3   vector width, must equal $clog2(NUM_IRQ)
//  SYNC_STAGES  2   flip-flop stages on each irq_in bit (>=2)
// PORTS
//  clk                 in   1        single clock, rising edge
//  reset_n             in   1        asynchronous active-low reset
//  irq_in              in   NUM_IRQ  raw async requests, active-high
//  level_or_edge_flag  in   1        0 = rising-edge capture, 1 = level capture
//  mask                in   NUM_IRQ  1 = channel masked (IMR)
//  inta                in   1        one-cycle acknowledge strobe from control logic
//  eoi                 in   1        one-cycle non-specific EOI strobe
//  eoi_specific        in   1        one-cycle specific EOI strobe
//  eoi_level           in   VEC_W    channel cleared by eoi_specific
//  int_out             out  1        registered interrupt request to CPU
//  vector_valid        out  1        one-cycle strobe, vector valid
//  vector              out  VEC_W    acknowledged channel index
//  irr                 out  NUM_IRQ  request register
//  isr                 out  NUM_IRQ  in-service register
// BEHAVIOUR
//  Reset: all sync flops, irr, isr, int_out, vector_valid, vector = 0; FSM = IDLE; takes effect mid-sequence.
//  Capture, edge mode: a 0->1 on the synchronised input sets irr[i]. The bit stays set until it is acknowledged.
//  Capture, level mode: irr[i] = synchronised input each cycle. It is not cleared by acknowledge.
//  Latency: irq_in -> irr is SYNC_STAGES+1 cycles; irr -> int_out is 1 cycle.
//  Mask only gates resolution; irr still captures masked channels.
//  Winner: lowest i with irr[i] & ~mask[i], and i < lowest set isr bit (strictly higher priority).
//  int_out = 1 iff a winner exists and FSM == IDLE; it is registered.
//  FSM states IDLE, ACK1, ACK2:
//   IDLE --inta--> ACK1: latch winner into vector, assert freeze, set isr[w], clear irr[w] (edge mode).
//    If no winner (spurious), latch vector = NUM_IRQ-1 and leave isr/irr unchanged.
//   ACK1 --inta--> ACK2: vector_valid = 1 for exactly this cycle.
//   ACK2 --(next cycle)--> IDLE: release freeze.
//   An inta in ACK2 is ignored. eoi in any state is processed.
//  Freeze (ACK1..ACK2): irr bits are not set. Edges detected while frozen go into pend[i] and are
//   ORed into irr on the cycle freeze drops. No edge is lost.
//  Edge capture and ack-clear of the same irr bit in the same cycle: capture wins, so irr stays 1.
//  eoi clears the lowest set isr bit. eoi_specific clears isr[eoi_level]; eoi_level >= NUM_IRQ is ignored.
//   eoi and eoi_specific together: both clears apply.
//  EOI and ack-set on the same isr bit in the same cycle: set wins.
//  Several isr bits may be set (nesting); priority masking uses the lowest set bit.
// CONFIGURATION
//  IRQ_AUTO_EOI_EN defined: the isr bit set at ACK1 is cleared automatically in the ACK2 cycle.
//   The eoi inputs still work.
//  IRQ_AUTO_EOI_EN undefined: isr bits are cleared only by eoi / eoi_specific.
// TESTING
//  Edge mode, 2-cycle pulse on irq_in[3]: irr=0x08 after 3 clk, int_out=1 on the next clk.
//   inta,inta -> vector_valid=1 with vector=3, isr=0x08, irr=0x00.
//  Edge, irq_in[5] and irq_in[2] together with mask=0x04: ack gives vector=5. Unmask channel 2:
//   int_out rises (2 outranks 5); nested ack gives isr=0x24.
//  Level mode, irq_in[1] held: irr[1] stays 1 after ack. int_out=0 while isr[1]=1.
//   eoi -> isr=0x00 and int_out=1 again.
//  Spurious: irr=0x01 dropped in level mode before the first inta.
//   Required: vector=7, isr=0x00, vector_valid still pulses once.
//  Freeze: rising edge on irq_in[6] during ACK1.
//   Required: irr[6] stays 0 until ACK2 exits, then irr=0x40.
//  Mid-ACK1 reset_n low: FSM IDLE, isr=0, int_out=0 immediately.
//   With IRQ_AUTO_EOI_EN, one ack leaves isr=0x00 after ACK2.

Source files
------------

// File: rtl/irq_capture_resolver.sv
// Interrupt request/in-service unit: per-channel sync + edge/level capture, fixed-priority resolve,
// two-pulse INTA FSM and EOI handling. Define IRQ_AUTO_EOI_EN to clear the acked ISR bit in ACK2.
module irq_capture_resolver #(
  parameter int NUM_IRQ     = 8,
  parameter int VEC_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_or_edge_flag,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               inta,
  input  logic               eoi,
  input  logic               eoi_specific,
  input  logic [VEC_W-1:0]   eoi_level,
  output logic               int_out,
  output logic               vector_valid,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [1:0]         fsm_state
);

  // Handshake: inta, eoi and eoi_specific are single-cycle strobes sampled on clk; vector_valid is a
  // one-cycle strobe (no back-pressure) and vector is stable from ACK1 until the next acknowledge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] synced, sync_prev, edges;
  logic [NUM_IRQ-1:0] pend, pend_next, irr_next, isr_next;
  logic [NUM_IRQ-1:0] eoi_clr, spec_clr, auto_clr, ack_set;
  logic               has_winner, isr_seen, ack_take;
  logic [VEC_W-1:0]   winner;

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [VEC_W-1:0] idx);
    logic [NUM_IRQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      v[i] = (int'(idx) == i);
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      sync_prev <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_in};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign edges  = synced & ~sync_prev;

  // Channels at or below the highest-priority in-service bit cannot win.
  always_comb begin
    has_winner = 1'b0;
    winner     = '0;
    isr_seen   = 1'b0;
    eoi_clr    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (isr[i] && !isr_seen) begin
        eoi_clr[i] = eoi;
      end
      if (isr[i]) begin
        isr_seen = 1'b1;
      end
      if (!isr_seen && !has_winner && irr[i] && !mask[i]) begin
        has_winner = 1'b1;
        winner     = VEC_W'(i);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (inta) state_next = ACK1;
      ACK1:    if (inta) state_next = ACK2;
      ACK2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ack_take     = (state == IDLE) && inta;
    vector_valid = (state == ACK2);
    fsm_state    = state;
  end

  assign ack_set  = (ack_take && has_winner) ? onehot(winner) : '0;
  assign spec_clr = (eoi_specific && (int'(eoi_level) < NUM_IRQ)) ? onehot(eoi_level) : '0;

`ifdef IRQ_AUTO_EOI_EN
  logic ack_hit;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_hit <= 1'b0;
    end else if (ack_take) begin
      ack_hit <= has_winner;
    end
  end
  assign auto_clr = ((state == ACK2) && ack_hit) ? onehot(vector) : '0;
`else
  assign auto_clr = '0;
`endif

  // Freeze spans ACK1..ACK2: edges park in pend and merge on the ACK2 -> IDLE edge.
  always_comb begin
    irr_next  = irr;
    pend_next = (state == ACK1) ? (pend | edges) : '0;
    if (level_or_edge_flag) begin
      irr_next = (state == ACK1) ? (irr & synced) : synced;
    end else begin
      case (state)
        IDLE:    irr_next = (irr & ~ack_set) | edges;
        ACK1:    irr_next = irr;
        ACK2:    irr_next = irr | pend | edges;
        default: irr_next = irr;
      endcase
    end
    isr_next = (isr & ~(eoi_clr | spec_clr | auto_clr)) | ack_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irr     <= '0;
      isr     <= '0;
      pend    <= '0;
      int_out <= 1'b0;
      vector  <= '0;
    end else begin
      irr     <= irr_next;
      isr     <= isr_next;
      pend    <= pend_next;
      int_out <= has_winner && (state == IDLE);
      if (ack_take) begin
        vector <= has_winner ? winner : VEC_W'(NUM_IRQ - 1);
      end
    end
  end

endmodule
